// File: rtl/bin2bcd_if.sv
// Handshake/bus bundle for the sequential binary-to-BCD converter.
//   master : drives start, bin_in; observes busy, done, bcd_out, overflow
//   slave  : the converter side
// BIN_W / DIGITS must match the converter instance.
interface bin2bcd_if #(
  parameter int unsigned BIN_W  = 7,
  parameter int unsigned DIGITS = 2
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, overflow
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, overflow
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 (double-dabble) binary-to-BCD converter, one input
// bit per clock, under a start/busy/done handshake. Feeds packed BCD operands
// to the downstream two-digit BCD adder.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - bin2bcd_if.slave: start, bin_in (in); busy, done, bcd_out,
//          overflow (out, all registered)
//
// Optional build macro BIN2BCD_SATURATE_EN: on overflow bcd_out is forced to
// all nines instead of the value modulo 10^DIGITS.
module bin2bcd_seq #(
  parameter int unsigned BIN_W  = 7,
  parameter int unsigned DIGITS = 2
) (
  input  logic       clk,
  input  logic       rst,
  bin2bcd_if.slave   bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   sh_q, sh_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovfo_q, ovfo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // one double-dabble step, computed from the current working registers
  logic [BCD_W-1:0]   adj;
  logic               shout;
  logic [BCD_W-1:0]   step_work;
  logic [BIN_W-1:0]   step_sh;
  logic               step_ovf;

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      work_q  <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovfo_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      work_q  <= work_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovfo_q  <= ovfo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // next-state, datapath step and registered-output next values
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    work_d  = work_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovfo_d  = ovfo_q;

    // add 3 to every digit >= 5 so the following doubling carries correctly
    adj = work_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
    // the bit leaving the top digit means the value no longer fits
    {shout, step_work, step_sh} = {adj, sh_q, 1'b0};
    step_ovf = ovf_q | shout;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sh_d    = bus.bin_in;
          work_d  = '0;
          ovf_d   = 1'b0;
          cnt_d   = CNT_W'(BIN_W);
          state_d = CONV;
        end
      end
      CONV: begin
        sh_d   = step_sh;
        work_d = step_work;
        ovf_d  = step_ovf;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          ovfo_d  = step_ovf;
`ifdef BIN2BCD_SATURATE_EN
          bcd_d   = step_ovf ? {DIGITS{4'h9}} : step_work;
`else
          bcd_d   = step_work;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CONV);
    done_d = (state_d == DONE);
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovfo_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (default BIN_W=7, DIGITS=2).
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bin2bcd_if #(.BIN_W(7), .DIGITS(2)) bus ();

  bin2bcd_seq #(.BIN_W(7), .DIGITS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef BIN2BCD_SATURATE_EN
  localparam logic [7:0] EXP_100 = 8'h99;
  localparam logic [7:0] EXP_127 = 8'h99;
`else
  localparam logic [7:0] EXP_100 = 8'h00;
  localparam logic [7:0] EXP_127 = 8'h27;
`endif

  // one-cycle start pulse; returns at the falling edge after the accept edge
  task automatic pulse_start(input logic [6:0] val);
    @(negedge clk);
    bus.bin_in = val;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.bin_in = ~val;
  endtask

  // sample at falling edges until done, bounded; lat counts from first sample
  task automatic wait_done(output int lat, output int busy_n, output bit seen,
                           output bit both);
    lat = 0; busy_n = 0; seen = 1'b0; both = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) @(negedge clk);
      if (bus.busy && bus.done) both = 1'b1;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        seen = 1'b1;
        lat  = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bus.start  = 1'b0;
    bus.bin_in = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.bcd_out !== 8'h00) begin errors++; $display("FAIL reset_bcd: got %h expected 00", bus.bcd_out); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.overflow); end
  endtask

  task automatic test_basic;
    int lat, bn; bit seen, both;
    pulse_start(7'd29);
    wait_done(lat, bn, seen, both);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL basic_done_seen: got %b expected 1", seen); end
    checks++; if (lat != 8) begin errors++; $display("FAIL basic_latency: got %0d expected 8", lat); end
    checks++; if (bn != 7) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 7", bn); end
    checks++; if (both !== 1'b0) begin errors++; $display("FAIL basic_busy_done_overlap: got %b expected 0", both); end
    checks++; if (bus.bcd_out !== 8'h29) begin errors++; $display("FAIL basic_bcd: got %h expected 29", bus.bcd_out); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b expected 0", bus.overflow); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b expected 0", bus.done); end
    repeat (3) @(negedge clk);
    checks++; if (bus.bcd_out !== 8'h29) begin errors++; $display("FAIL basic_hold: got %h expected 29", bus.bcd_out); end
  endtask

  task automatic test_back_to_back;
    int lat, bn; bit seen, both;
    pulse_start(7'd29);
    wait_done(lat, bn, seen, both);
    checks++; if (bus.bcd_out !== 8'h29) begin errors++; $display("FAIL b2b_first: got %h expected 29", bus.bcd_out); end
    pulse_start(7'd17);
    wait_done(lat, bn, seen, both);
    checks++; if (lat != 8) begin errors++; $display("FAIL b2b_latency: got %0d expected 8", lat); end
    checks++; if (bus.bcd_out !== 8'h17) begin errors++; $display("FAIL b2b_second: got %h expected 17", bus.bcd_out); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b expected 0", bus.overflow); end
  endtask

  task automatic test_extremes;
    logic [6:0] vals [4];
    logic [7:0] exp_bcd [4];
    logic       exp_ovf [4];
    int lat, bn; bit seen, both;
    vals[0] = 7'd0;   exp_bcd[0] = 8'h00;   exp_ovf[0] = 1'b0;
    vals[1] = 7'd99;  exp_bcd[1] = 8'h99;   exp_ovf[1] = 1'b0;
    vals[2] = 7'd100; exp_bcd[2] = EXP_100; exp_ovf[2] = 1'b1;
    vals[3] = 7'd127; exp_bcd[3] = EXP_127; exp_ovf[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pulse_start(vals[k]);
      wait_done(lat, bn, seen, both);
      checks++; if (!seen || lat != 8) begin errors++; $display("FAIL extreme_latency in=%0d: got %0d expected 8", vals[k], lat); end
      checks++; if (bus.bcd_out !== exp_bcd[k]) begin errors++; $display("FAIL extreme_bcd in=%0d: got %h expected %h", vals[k], bus.bcd_out, exp_bcd[k]); end
      checks++; if (bus.overflow !== exp_ovf[k]) begin errors++; $display("FAIL extreme_ovf in=%0d: got %b expected %b", vals[k], bus.overflow, exp_ovf[k]); end
    end
  endtask

  task automatic test_ignored_start;
    bit seen; int extra_done, extra_busy;
    seen = 1'b0; extra_done = 0; extra_busy = 0;
    pulse_start(7'd50);
    repeat (2) @(negedge clk);
    bus.bin_in = 7'd7;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL ignore_done_seen: got %b expected 1", seen); end
    // re-pulse during the DONE cycle
    bus.bin_in = 7'd7;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) extra_done++;
      if (bus.busy) extra_busy++;
      @(negedge clk);
    end
    checks++; if (extra_done != 0) begin errors++; $display("FAIL ignore_extra_done: got %0d expected 0", extra_done); end
    checks++; if (extra_busy != 0) begin errors++; $display("FAIL ignore_extra_busy: got %0d expected 0", extra_busy); end
    checks++; if (bus.bcd_out !== 8'h50) begin errors++; $display("FAIL ignore_bcd: got %h expected 50", bus.bcd_out); end
  endtask

  task automatic test_reset_mid_conv;
    int dn, bn;
    dn = 0; bn = 0;
    pulse_start(7'd127);
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", bus.busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", bus.done); end
    checks++; if (bus.bcd_out !== 8'h00) begin errors++; $display("FAIL midrst_bcd: got %h expected 00", bus.bcd_out); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL midrst_ovf: got %b expected 0", bus.overflow); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) dn++;
      if (bus.busy) bn++;
    end
    checks++; if (dn != 0) begin errors++; $display("FAIL midrst_no_done: got %0d expected 0", dn); end
    checks++; if (bn != 0) begin errors++; $display("FAIL midrst_no_busy: got %0d expected 0", bn); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_extremes();
    test_ignored_start();
    test_reset_mid_conv();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
